// File: rtl/bus_master_ctrl_if.sv
// Pin-level req/ack/err bus between the queued master and a slave.
interface bus_master_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DW         = 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DW-1:0]         wr_data;
    logic                  rw;
    logic                  req;
    logic [DW-1:0]         rd_data;
    logic                  ack;
    logic                  err;

    modport master (
        output address, wr_data, rw, req,
        input  rd_data, ack, err
    );

    modport slave (
        input  address, wr_data, rw, req,
        output rd_data, ack, err
    );
endinterface

// File: rtl/bus_master_ctrl.sv
// Queued bus master: command FIFO feeding a single-outstanding req/ack/err engine
// with timeout detection, bounded retry on err and one response per command.
module bus_master_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DW         = 8,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [DW-1:0]              cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW-1:0]              rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic                       busy,
    output logic [$clog2(CMD_DEPTH):0] cmd_count,
    bus_master_ctrl_if.master          bus
);
    localparam int unsigned PW = $clog2(CMD_DEPTH);
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned EW = 1 + ADDR_WIDTH + DW;
    localparam logic [WW-1:0] WaitLast = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StRsp} state_e;

    state_e        state;
    logic [EW-1:0] mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    retry_cnt;

    assign cmd_ready = (cmd_count != (PW + 1)'(CMD_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == StIdle) && (cmd_count != '0);
    assign busy      = (cmd_count != '0) || (state != StIdle);

    // Storage needs no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            bus.req     <= 1'b0;
            bus.address <= '0;
            bus.wr_data <= '0;
            bus.rw      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (pop) begin
                        {bus.rw, bus.address, bus.wr_data} <= mem[rd_ptr];
                        wait_cnt  <= '0;
                        retry_cnt <= '0;
                        bus.req   <= 1'b1;
                        state     <= StReq;
                    end
                end
                StReq: begin
                    // err outranks a simultaneous ack.
                    if (bus.err) begin
                        bus.req <= 1'b0;
                        if (retry_cnt < MaxRetry) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= StGap;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= StRsp;
                        end
                    end else if (bus.ack) begin
                        if (bus.rw) rsp_rdata <= bus.rd_data;
                        bus.req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= StRsp;
                    end else if ((TIMEOUT != 0) && (wait_cnt == WaitLast)) begin
                        bus.req     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= StRsp;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StGap: begin
                    wait_cnt <= '0;
                    bus.req  <= 1'b1;
                    state    <= StReq;
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: scripted slave, req monitor and response scoreboard.
module tb_bus_master_ctrl;
    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  cmd_count;

    bus_master_ctrl_if #(.ADDR_WIDTH(16), .DW(8)) bus ();

    bus_master_ctrl #(
        .ADDR_WIDTH(16),
        .DW        (8),
        .CMD_DEPTH (4),
        .TIMEOUT   (8),
        .MAX_RETRY (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .cmd_count  (cmd_count),
        .bus        (bus)
    );

    int   tests = 0;
    int   fails = 0;
    rsp_t sb[$];
    int   rsp_seen = 0;

    // Slave configuration, written only by the stimulus block.
    int lat = 1;
    int err_budget = 0;
    bit silent = 0;
    bit inject_ack = 0;
    int clr_tok = 0;

    // Monitor state, written only by the slave block.
    int   clr_seen = 0;
    int   pulses = 0;
    int   hi = 0;
    int   low_run = 0;
    int   pulse_lens[$];
    int   gaps[$];
    logic rw_start = 1'b0;
    logic rw_bad = 1'b0;
    logic req_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave reacts #2 after each edge so ack/err land within the current req cycle.
    always @(posedge clk) begin
        #2;
        if (clr_tok != clr_seen) begin
            clr_seen = clr_tok;
            pulses = 0;
            low_run = 0;
            pulse_lens.delete();
            gaps.delete();
            rw_bad = 1'b0;
        end
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rd_data = 8'h00;
        if (bus.req) begin
            if (!req_prev) begin
                pulses++;
                if (pulses > 1) gaps.push_back(low_run);
                rw_start = bus.rw;
            end
            hi++;
            low_run = 0;
            if (bus.rw !== rw_start) rw_bad = 1'b1;
            if (!silent && hi == lat) begin
                if (pulses <= err_budget) begin
                    bus.err = 1'b1;
                end else begin
                    bus.ack = 1'b1;
                    bus.rd_data = bus.address[7:0] ^ 8'h2C;
                end
            end
        end else begin
            if (req_prev) pulse_lens.push_back(hi);
            hi = 0;
            low_run++;
        end
        if (inject_ack) begin
            bus.ack = 1'b1;
            bus.rd_data = 8'hEE;
        end
        req_prev = bus.req;
    end

    // Scoreboard: a handshake visible at negedge completes at the next posedge.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_seen++;
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
        end
    end

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic push(input logic r, input logic [15:0] a, input logic [7:0] d,
                        input logic e_err, input logic e_to);
        rsp_t e;
        bit   done = 0;
        cmd_valid = 1'b1;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            done = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("push_accepted", 32'(done), 32'd1);
        if (done) begin
            e.rdata = (r && !e_err && !e_to) ? (a[7:0] ^ 8'h2C) : 8'h00;
            e.err   = e_err;
            e.to    = e_to;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || rsp_valid || sb.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_sb"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_rw = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_rw", 32'(bus.rw), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_count", 32'(cmd_count), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write with ack in the third req cycle.
        lat = 3; err_budget = 0; silent = 0; clr_tok++;
        push(1'b0, 16'h1234, 8'hA5, 1'b0, 1'b0);
        wait_idle("wr");
        chk("wr_pulses", 32'(pulse_lens.size()), 32'd1);
        chk("wr_req_len", 32'(pulse_lens[0]), 32'd3);
        chk("wr_address", 32'(bus.address), 32'h1234);
        chk("wr_wr_data", 32'(bus.wr_data), 32'hA5);
        chk("wr_rw", 32'(bus.rw), 32'd0);

        // Read returning 0x3C.
        lat = 2; clr_tok++;
        push(1'b1, 16'h0010, 8'h00, 1'b0, 1'b0);
        wait_idle("rd");
        chk("rd_pulses", 32'(pulse_lens.size()), 32'd1);
        chk("rd_rw_start", 32'(rw_start), 32'd1);
        chk("rd_rw_stable", 32'(rw_bad), 32'd0);

        // Two errs then ack: three pulses, single-cycle gaps.
        lat = 1; err_budget = 2; clr_tok++;
        push(1'b0, 16'h0200, 8'h11, 1'b0, 1'b0);
        wait_idle("retry_ok");
        chk("retry_ok_pulses", 32'(pulse_lens.size()), 32'd3);
        chk("retry_ok_gaps", 32'(gaps.size()), 32'd2);
        chk("retry_ok_gap0", 32'(gaps[0]), 32'd1);
        chk("retry_ok_gap1", 32'(gaps[1]), 32'd1);

        // Err on every attempt: reported after three pulses.
        err_budget = 15; clr_tok++;
        push(1'b1, 16'h0300, 8'h00, 1'b1, 1'b0);
        wait_idle("retry_fail");
        chk("retry_fail_pulses", 32'(pulse_lens.size()), 32'd3);

        // Silent slave: timeout after 8 req cycles, late ack ignored.
        err_budget = 0; silent = 1; clr_tok++;
        push(1'b1, 16'h0400, 8'h00, 1'b0, 1'b1);
        wait_idle("to");
        chk("to_pulses", 32'(pulse_lens.size()), 32'd1);
        chk("to_req_len", 32'(pulse_lens[0]), 32'd8);
        base = rsp_seen;
        inject_ack = 1;
        @(posedge clk);
        #1;
        inject_ack = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("late_ack_no_rsp", 32'(rsp_seen), 32'(base));
        chk("late_ack_no_req", 32'(pulse_lens.size()), 32'd1);
        chk("late_ack_busy", 32'(busy), 32'd0);

        // Fill the FIFO with the response path stalled.
        silent = 0; lat = 1; rsp_ready = 0; clr_tok++;
        base = rsp_seen;
        push(1'b1, 16'h0101, 8'h00, 1'b0, 1'b0);
        push(1'b0, 16'h0102, 8'h22, 1'b0, 1'b0);
        push(1'b1, 16'h0103, 8'h00, 1'b0, 1'b0);
        push(1'b1, 16'h0104, 8'h00, 1'b0, 1'b0);
        push(1'b0, 16'h0105, 8'h55, 1'b0, 1'b0);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_cmd_count", 32'(cmd_count), 32'd4);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h0106; cmd_wdata = 8'h66;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("full_refused_count", 32'(cmd_count), 32'd4);
        chk("full_rsp_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1;
        wait_idle("fifo");
        chk("fifo_rsp_count", 32'(rsp_seen - base), 32'd5);
        chk("fifo_pulses", 32'(pulse_lens.size()), 32'd5);

        // Reset while req is high with a second command queued.
        silent = 1; clr_tok++;
        push(1'b0, 16'h0500, 8'h77, 1'b0, 1'b0);
        push(1'b0, 16'h0501, 8'h78, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !bus.req; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_req", 32'(bus.req), 32'd1);
        base = rsp_seen;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_req", 32'(bus.req), 32'd0);
        chk("mid_rst_cmd_count", 32'(cmd_count), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        sb.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_no_rsp", 32'(rsp_seen), 32'(base));
        chk("post_rst_busy", 32'(busy), 32'd0);
        silent = 0; lat = 2; clr_tok++;
        push(1'b1, 16'h0077, 8'h00, 1'b0, 1'b0);
        wait_idle("post_rst");
        chk("post_rst_rsp", 32'(rsp_seen - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
